// File: rtl/lane_serializer.sv
// Purpose: serializes one shifted LANES x LANE_W word into a lane-per-cycle valid/ready stream, dropping illegal words.
// Latency: word accepted at edge N shows lane 0 after edge N; cnt lanes take cnt cycles at full rate, back-to-back words add no bubble.
// Backpressure: out_ready low holds out_lane/out_last; in_ready is high only when idle or when the last lane is being taken.
// Optional: define LANE_SER_FILL_EMIT_EN to emit all LANES lanes (fill lanes included) regardless of in_shift.
module lane_serializer #(
    parameter int LANE_W  = 5,
    parameter int LANES   = 10,
    parameter int SHIFT_W = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANE_W*LANES-1:0]   in_data,
    input  logic [SHIFT_W-1:0]        in_shift,
    input  logic                      in_word_ok,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W-1:0]         out_lane,
    output logic                      out_last,
    output logic                      err_drop
);

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                    state;
    logic [LANE_W*LANES-1:0]   word;
    logic [CNT_W-1:0]          idx;
    logic [CNT_W-1:0]          cnt;

    logic [CNT_W-1:0]          idx_nxt;
    logic [LANE_W-1:0]         nxt_lane;
    logic [CNT_W-1:0]          cnt_new;
    logic                      accept;

    // A new word may enter when idle or in the same cycle the current word's last lane leaves.
    assign in_ready = (state == IDLE) | (out_valid & out_ready & out_last);
    assign accept   = in_valid & in_ready;

`ifdef LANE_SER_FILL_EMIT_EN
    assign cnt_new = CNT_W'(LANES);
`else
    assign cnt_new = CNT_W'(LANES) - CNT_W'(in_shift);
`endif

    // Select the lane that follows the one currently presented.
    always_comb begin
        idx_nxt  = idx + CNT_W'(1);
        nxt_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (idx_nxt == CNT_W'(i)) begin
                nxt_lane = word[i*LANE_W +: LANE_W];
            end
        end
    end

    // Control FSM with registered lane outputs; a load in the last-beat cycle overrides the return to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            word      <= '0;
            idx       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_last  <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            err_drop <= 1'b0;
            if (state == SEND && out_ready) begin
                if (!out_last) begin
                    idx      <= idx_nxt;
                    out_lane <= nxt_lane;
                    out_last <= (idx_nxt == cnt - CNT_W'(1));
                end else begin
                    state     <= IDLE;
                    idx       <= '0;
                    out_valid <= 1'b0;
                    out_lane  <= '0;
                    out_last  <= 1'b0;
                end
            end
            if (accept) begin
                if (in_word_ok) begin
                    state     <= SEND;
                    word      <= in_data;
                    cnt       <= cnt_new;
                    idx       <= '0;
                    out_valid <= 1'b1;
                    out_lane  <= in_data[LANE_W-1:0];
                    out_last  <= (cnt_new == CNT_W'(1));
                end else begin
                    err_drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_serializer.sv
// Purpose: randomized and directed checks of lane_serializer against a queue-of-beats reference model.
// Latency: model expects lane 0 one edge after acceptance and one lane per out_ready handshake.
// Backpressure: out_ready is driven directed or random; stalled beats must stay on the output unchanged.
module tb_lane_serializer;

    localparam int LANE_W  = 5;
    localparam int LANES   = 10;
    localparam int SHIFT_W = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANE_W*LANES-1:0] in_data = '0;
    logic [SHIFT_W-1:0]      in_shift = '0;
    logic                    in_word_ok = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [LANE_W-1:0]       out_lane;
    logic                    out_last;
    logic                    err_drop;

    lane_serializer #(.LANE_W(LANE_W), .LANES(LANES), .SHIFT_W(SHIFT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shift   (in_shift),
        .in_word_ok (in_word_ok),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_lane   (out_lane),
        .out_last   (out_last),
        .err_drop   (err_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANE_W-1:0] lane;
        logic              last;
    } beat_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    beat_t       q[$];
    logic [4:0]  got[$];
    int          got_cyc[$];
    bit          checking = 0;
    bit          exp_err  = 0;
    bit          rdy_rand = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lanes_for(input logic [SHIFT_W-1:0] sh);
`ifdef LANE_SER_FILL_EMIT_EN
        return LANES;
`else
        return LANES - int'(sh);
`endif
    endfunction

    // Reference model: a word becomes a list of beats; the block is busy exactly while beats remain.
    always @(negedge clk) begin
        if (checking) begin
            chk("err_drop", {63'd0, err_drop}, {63'd0, exp_err});
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
            chk("in_ready", {63'd0, in_ready},
                {63'd0, (q.size() == 0) || (q.size() == 1 && out_ready)});
            if (out_valid && q.size() != 0) begin
                chk("out_lane", {59'd0, out_lane}, {59'd0, q[0].lane});
                chk("out_last", {63'd0, out_last}, {63'd0, q[0].last});
                if (out_ready) begin
                    got.push_back(out_lane);
                    got_cyc.push_back(cyc);
                    void'(q.pop_front());
                end
            end
            exp_err = 0;
            if (!rst_n) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                if (!in_word_ok) begin
                    exp_err = 1;
                end else begin
                    int n;
                    n = lanes_for(in_shift);
                    for (int j = 0; j < n; j++) begin
                        beat_t b;
                        b.lane = in_data[j*LANE_W +: LANE_W];
                        b.last = (j == n - 1);
                        q.push_back(b);
                    end
                end
            end
        end
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offer one word and hold it until accepted; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [LANE_W*LANES-1:0] d, input logic [SHIFT_W-1:0] sh,
                             input logic ok);
        bit acc;
        acc = 0;
        in_data    = d;
        in_shift   = sh;
        in_word_ok = ok;
        in_valid   = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept_timeout", {63'd0, acc}, 64'd1);
    endtask

    // Wait until the model and DUT have both drained.
    task automatic wait_idle();
        bit done;
        done = 0;
        for (int t = 0; t < 600 && !done; t++) begin
            @(negedge clk);
            done = (q.size() == 0) && !out_valid;
        end
        @(posedge clk);
        #1;
        chk("drain_timeout", {63'd0, done}, 64'd1);
    endtask

    function automatic logic [LANE_W*LANES-1:0] make_word(input int base);
        logic [LANE_W*LANES-1:0] w;
        w = '0;
        for (int k = 0; k < LANES; k++) w[k*LANE_W +: LANE_W] = 5'((base + k) & 31);
        return w;
    endfunction

    initial begin
        logic [LANE_W*LANES-1:0] w;
        int n_exp;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_lane", {59'd0, out_lane}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_err_drop", {63'd0, err_drop}, 64'd0);
        checking  = 1;
        out_ready = 1'b1;

        // Lane k holds k, shift 0: ten consecutive beats.
        got.delete(); got_cyc.delete();
        send_word(make_word(0), 3'd0, 1'b1);
        wait_idle();
        chk("t1_count", 64'(got.size()), 64'd10);
        for (int k = 0; k < 10; k++) chk("t1_lane", {59'd0, got[k]}, 64'(k));
        chk("t1_span", 64'(got_cyc[9] - got_cyc[0]), 64'd9);

        // Shift 4: lanes 0x11..0x16, fill lanes zero.
        w = '0;
        for (int k = 0; k < 6; k++) w[k*LANE_W +: LANE_W] = 5'(5'h11 + k);
        got.delete(); got_cyc.delete();
        send_word(w, 3'd4, 1'b1);
        wait_idle();
`ifdef LANE_SER_FILL_EMIT_EN
        n_exp = 10;
`else
        n_exp = 6;
`endif
        chk("t2_count", 64'(got.size()), 64'(n_exp));
        chk("t2_first", {59'd0, got[0]}, 64'h11);
        chk("t2_sixth", {59'd0, got[5]}, 64'h16);

        // Illegal word (shift 5) is dropped with a one-cycle error pulse.
        send_word(make_word(7), 3'd5, 1'b0);
        chk("t3_err_hi", {63'd0, err_drop}, 64'd1);
        chk("t3_no_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("t3_err_lo", {63'd0, err_drop}, 64'd0);
        chk("t3_ready", {63'd0, in_ready}, 64'd1);

        // out_ready pattern 1,0,0,1 mid-word.
        got.delete(); got_cyc.delete();
        send_word(make_word(1), 3'd0, 1'b1);
        out_ready = 1'b1; @(posedge clk); #1;
        out_ready = 1'b0; @(posedge clk); #1;
        chk("t4_stall_lane", {59'd0, out_lane}, 64'd2);
        out_ready = 1'b0; @(posedge clk); #1;
        chk("t4_stall_lane2", {59'd0, out_lane}, 64'd2);
        out_ready = 1'b1;
        wait_idle();
        chk("t4_count", 64'(got.size()), 64'd10);
        for (int k = 0; k < 10; k++) chk("t4_lane", {59'd0, got[k]}, 64'(k + 1));

        // Back-to-back shift 0 then shift 2: no bubble between words.
        got.delete(); got_cyc.delete();
        send_word(make_word(3), 3'd0, 1'b1);
        send_word(make_word(20), 3'd2, 1'b1);
        wait_idle();
`ifdef LANE_SER_FILL_EMIT_EN
        n_exp = 20;
`else
        n_exp = 18;
`endif
        chk("t5_count", 64'(got.size()), 64'(n_exp));
        chk("t5_span", 64'(got_cyc[got.size()-1] - got_cyc[0]), 64'(n_exp - 1));
        chk("t5_second_first", {59'd0, got[10]}, 64'd20);

        // Reset at beat 3 aborts the word; next word starts at lane 0.
        send_word(make_word(9), 3'd0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_beat3", {59'd0, out_lane}, 64'd12);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_last", {63'd0, out_last}, 64'd0);
        chk("t6_lane", {59'd0, out_lane}, 64'd0);
        chk("t6_ready", {63'd0, in_ready}, 64'd1);
        got.delete(); got_cyc.delete();
        send_word(make_word(25), 3'd1, 1'b1);
        wait_idle();
        chk("t6_restart", {59'd0, got[0]}, 64'd25);

        // Random traffic with random backpressure and gaps.
        rdy_rand = 1;
        for (int i = 0; i < 300; i++) begin
            logic [SHIFT_W-1:0] sh;
            sh = 3'($urandom_range(0, 7));
            w  = {18'($urandom), $urandom};
            send_word(w, sh, sh <= 3'd4);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rdy_rand = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
